// File: rtl/transform_pkg.sv
// transform_pkg: coordinate/tilt widths, screen pivot and extent constants shared by the tilt pipeline
package transform_pkg;
   localparam int W    = 11;
   localparam int S    = 11;
   localparam int FRAC = 4;
   localparam int CX   = 320;
   localparam int CY   = 240;
   localparam int XMAX = 639;
   localparam int YMAX = 479;
   localparam int DW   = W + 1;
   localparam int PW   = W + S + 1;
   localparam int SW   = W + S + 2;
endpackage

// File: rtl/tilt_axis.sv
// tilt_axis: one axis of the tilt map (offset, multiply, shift-add); CLAMP_EN selects clamp+oob over wrap
module tilt_axis
   import transform_pkg::*;
#(
   parameter int PIVOT = CX,
   parameter int MAX   = XMAX
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en_i,
   input  logic [W-1:0]        c_i,
   input  logic signed [S-1:0] sin_i,
   output logic [W-1:0]        c_o,
   output logic                oob_o
);
   logic [W-1:0]         c1_q, c2_q, c_d;
   logic signed [DW-1:0] d1_q;
   logic signed [PW-1:0] p2_q, p_sh;
   logic signed [SW-1:0] sum;
   logic                 oob_d;
   // floor-rounded shift-add, then clamp into the screen or wrap modulo 2^W
   always_comb begin
      p_sh = p2_q >>> FRAC;
      sum = $signed({{(SW-W){1'b0}}, c2_q}) + SW'(p_sh);
`ifdef CLAMP_EN
      c_d = sum < 0 ? '0 : sum > SW'(MAX) ? W'(MAX) : sum[W-1:0];
      oob_d = sum < 0 || sum > SW'(MAX);
`else
      c_d = sum[W-1:0];
      oob_d = 1'b0;
`endif
   end
   // S1 coord and pivot offset, S2 product with the tilt live at entry, S3 mapped output
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         c1_q  <= '0;
         d1_q  <= '0;
         c2_q  <= '0;
         p2_q  <= '0;
         c_o   <= '0;
         oob_o <= 1'b0;
      end else if (en_i) begin
         c1_q  <= c_i;
         d1_q  <= $signed({1'b0, c_i}) - DW'(PIVOT);
         c2_q  <= c1_q;
         p2_q  <= PW'(d1_q) * PW'(sin_i);
         c_o   <= c_d;
         oob_o <= oob_d;
      end
endmodule

// File: rtl/transform_pipeline.sv
// transform_pipeline: 3-stage valid/ready tilt mapper with frame-synchronous tilt; CLAMP_EN adds clamping/oob
module transform_pipeline
   import transform_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                tilt_load,
   input  logic signed [S-1:0] sin_x,
   input  logic signed [S-1:0] sin_y,
   input  logic                frame_start,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [W-1:0]        x,
   input  logic [W-1:0]        y,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [W-1:0]        x_out,
   output logic [W-1:0]        y_out,
   output logic                oob
);
   logic                adv, v1_q, v2_q, ov_q, oob_x, oob_y;
   logic signed [S-1:0] shx_q, shy_q, ax_q, ay_q;
   assign adv       = out_ready | ~ov_q;
   assign in_ready  = adv;
   assign out_valid = ov_q;
   assign oob       = oob_x | oob_y;
   // valid chain moves with the global stall; tilt shadow/active update regardless of stall
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         v1_q  <= 1'b0;
         v2_q  <= 1'b0;
         ov_q  <= 1'b0;
         shx_q <= '0;
         shy_q <= '0;
         ax_q  <= '0;
         ay_q  <= '0;
      end else begin
         if (adv) begin
            v1_q <= in_valid;
            v2_q <= v1_q;
            ov_q <= v2_q;
         end
         if (tilt_load) begin
            shx_q <= sin_x;
            shy_q <= sin_y;
         end
         if (frame_start) begin
            ax_q <= tilt_load ? sin_x : shx_q;
            ay_q <= tilt_load ? sin_y : shy_q;
         end
      end
   tilt_axis #(.PIVOT(CX), .MAX(XMAX)) u_x (
      .clk(clk), .rst_n(rst_n), .en_i(adv), .c_i(x), .sin_i(ax_q), .c_o(x_out), .oob_o(oob_x)
   );
   tilt_axis #(.PIVOT(CY), .MAX(YMAX)) u_y (
      .clk(clk), .rst_n(rst_n), .en_i(adv), .c_i(y), .sin_i(ay_q), .c_o(y_out), .oob_o(oob_y)
   );
endmodule
